// File: rtl/audio_clock_pkg.sv
// Shared types and default constants for the audio clock generator.
// Optional LR frame clock is enabled by defining AUDIO_CLOCK_LRCLK_EN.
package audio_clock_pkg;

    typedef enum logic [1:0] {
        StUnlocked,
        StSettle,
        StRun
    } clk_state_e;

    localparam int unsigned DefAccW         = 24;
    localparam int unsigned DefLockCycles   = 1024;
    localparam int unsigned DefBclkPerFrame = 64;

endpackage

// File: rtl/audio_clock_gen_if.sv
// Control and clock-output bundle of the audio clock generator.
// lrclk is present only when AUDIO_CLOCK_LRCLK_EN is defined.
interface audio_clock_gen_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned ACC_W = 24
) ();

    logic                    pll_locked;
    logic                    enable;
    logic                    load;
    logic [N_CH*ACC_W-1:0]   inc;
    logic [N_CH-1:0]         clk_out;
    logic [N_CH-1:0]         tick;
    logic                    locked;
`ifdef AUDIO_CLOCK_LRCLK_EN
    logic [N_CH-1:0]         lrclk;

    modport master (
        output pll_locked, enable, load, inc,
        input  clk_out, tick, locked, lrclk
    );

    modport slave (
        input  pll_locked, enable, load, inc,
        output clk_out, tick, locked, lrclk
    );
`else
    modport master (
        output pll_locked, enable, load, inc,
        input  clk_out, tick, locked
    );

    modport slave (
        input  pll_locked, enable, load, inc,
        output clk_out, tick, locked
    );
`endif

endinterface

// File: rtl/audio_clock_nco.sv
// One NCO channel: increment register, phase accumulator, square clock and rise tick.
// With AUDIO_CLOCK_LRCLK_EN a tick counter also drives a per-channel frame clock.
module audio_clock_nco
    import audio_clock_pkg::*;
#(
    parameter int unsigned ACC_W          = DefAccW,
    parameter int unsigned BCLK_PER_FRAME = DefBclkPerFrame
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             enable,
    input  logic             load,
    input  logic [ACC_W-1:0] inc,
    output logic             clk_out,
    output logic             tick
`ifdef AUDIO_CLOCK_LRCLK_EN
    ,
    output logic             lrclk
`endif
);

    logic [ACC_W-1:0] inc_reg;
    logic [ACC_W-1:0] acc;
    logic             adv;
    logic             rise;

    always_comb begin
        adv  = run && enable && !load;
        rise = adv && acc[ACC_W-1] && !clk_out;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            inc_reg <= '0;
            acc     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (load) begin
                inc_reg <= inc;
            end
            tick <= rise;
            if (load || !run) begin
                acc     <= '0;
                clk_out <= 1'b0;
            end else if (enable) begin
                acc     <= acc + inc_reg;
                clk_out <= acc[ACC_W-1];
            end
        end
    end

`ifdef AUDIO_CLOCK_LRCLK_EN
    localparam int unsigned Half = BCLK_PER_FRAME / 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;

    logic [CntW-1:0] tick_cnt;

    // Toggle lands on the same edge that raises the Half-th tick of the half frame.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            lrclk    <= 1'b0;
        end else if (load || !run) begin
            tick_cnt <= '0;
            lrclk    <= 1'b0;
        end else if (rise) begin
            if (tick_cnt == CntW'(Half - 1)) begin
                tick_cnt <= '0;
                lrclk    <= ~lrclk;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/audio_clock_gen.sv
// Multi-channel audio clock generator: PLL lock qualification FSM plus N_CH NCO channels.
// Define AUDIO_CLOCK_LRCLK_EN to add per-channel LR frame clocks.
module audio_clock_gen
    import audio_clock_pkg::*;
#(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned ACC_W          = DefAccW,
    parameter int unsigned LOCK_CYCLES    = DefLockCycles,
    parameter int unsigned BCLK_PER_FRAME = DefBclkPerFrame
) (
    input logic              refclk,
    input logic              rst_n,
    audio_clock_gen_if.slave bus
);

    localparam int unsigned SettleW = $clog2(LOCK_CYCLES);

    logic               lock_meta;
    logic               lock_sync;
    clk_state_e         state;
    logic [SettleW-1:0] settle_cnt;
    logic               locked;
    logic [N_CH-1:0]    clk_out_v;
    logic [N_CH-1:0]    tick_v;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StUnlocked;
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            case (state)
                StUnlocked: begin
                    if (lock_sync) begin
                        state      <= StSettle;
                        settle_cnt <= '0;
                    end
                end
                StSettle: begin
                    if (!lock_sync) begin
                        state  <= StUnlocked;
                        locked <= 1'b0;
                    end else if (settle_cnt == SettleW'(LOCK_CYCLES - 1)) begin
                        state  <= StRun;
                        locked <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (!lock_sync) begin
                        state  <= StUnlocked;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= StUnlocked;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUDIO_CLOCK_LRCLK_EN
    logic [N_CH-1:0] lrclk_v;
    assign bus.lrclk = lrclk_v;
`endif

    // locked is exactly "state is RUN", so it doubles as the channel run qualifier.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        audio_clock_nco #(
            .ACC_W          (ACC_W),
            .BCLK_PER_FRAME (BCLK_PER_FRAME)
        ) u_nco (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .run     (locked),
            .enable  (bus.enable),
            .load    (bus.load),
            .inc     (bus.inc[g*ACC_W +: ACC_W]),
            .clk_out (clk_out_v[g]),
            .tick    (tick_v[g])
`ifdef AUDIO_CLOCK_LRCLK_EN
            ,
            .lrclk   (lrclk_v[g])
`endif
        );
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.locked  = locked;

endmodule

// File: doc/audio_clock_gen.md
AUDIO_CLOCK_GEN -- requirements
Module: audio_clock_gen

Interface
REQ-001 Parameter N_CH, default 2, number of independent clock channels (1..8).
REQ-002 Parameter ACC_W, default 24, phase-accumulator width in bits (16..32).
REQ-003 Parameter LOCK_CYCLES, default 1024, consecutive synced-lock cycles required before RUN (>=2).
REQ-004 Parameter BCLK_PER_FRAME, default 64, clk_out periods per LR frame (even, >=2).
REQ-005 refclk  in  1  single clock for all logic (typically the PLL audio output).
REQ-006 rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-007 pll_locked  in  1  asynchronous lock flag from the upstream PLL.
REQ-008 enable  in  1  high = accumulators advance; low = accumulators hold.
REQ-009 load  in  1  single-cycle strobe that latches inc.
REQ-010 inc  in  N_CH*ACC_W  per-channel phase increment, channel k at bits [k*ACC_W +: ACC_W].
REQ-011 clk_out  out  N_CH  per-channel square clock, f = f_refclk*inc/2^ACC_W.
REQ-012 tick  out  N_CH  one-cycle strobe coincident with each clk_out rising edge.
REQ-013 locked  out  1  high only in RUN state.
REQ-014 lrclk  out  N_CH  per-channel frame clock (present only with AUDIO_CLOCK_LRCLK_EN).

Function
REQ-015 pll_locked SHALL pass through a two-flop synchroniser before any use; raw pll_locked is never used.
REQ-016 Control FSM SHALL have states UNLOCKED, SETTLE, RUN.
REQ-017 UNLOCKED -> SETTLE when synced lock =1; settle counter cleared on entry.
REQ-018 SETTLE: counter increments each cycle; synced lock =0 -> UNLOCKED; counter == LOCK_CYCLES-1 -> RUN.
REQ-019 RUN: synced lock =0 -> UNLOCKED next cycle; locked deasserts same edge.
REQ-020 On load=1, inc_reg SHALL capture inc and all accumulators SHALL clear to 0 on the same edge; new increments apply from the next cycle.
REQ-021 inc_reg SHALL capture on load in any FSM state.
REQ-022 In RUN with enable=1, acc_k <= acc_k + inc_reg_k modulo 2^ACC_W (wrap silently, no saturation).
REQ-023 clk_out_k SHALL be registered acc_k[ACC_W-1]; latency one cycle after the accumulator update.
REQ-024 tick_k SHALL be 1 for exactly one cycle when clk_out_k transitions 0->1.
REQ-025 inc_reg_k =0 SHALL hold clk_out_k low and tick_k low indefinitely.
REQ-026 enable=0 in RUN SHALL freeze accumulators and clk_out; no tick generated.
REQ-027 Outside RUN, accumulators, clk_out, tick, lrclk SHALL be held at 0.
REQ-028 load coincident with lock loss: FSM goes UNLOCKED, inc_reg still captures.

Reset
REQ-029 rst_n low SHALL asynchronously force: FSM UNLOCKED, settle counter 0, synchroniser 0, inc_reg 0, accumulators 0, clk_out 0, tick 0, locked 0, lrclk 0.
REQ-030 Reset release SHALL be synchronous to refclk; first state change occurs no earlier than two cycles after release (synchroniser depth).

Configuration
REQ-031 Macro AUDIO_CLOCK_LRCLK_EN defined: per-channel tick counter; lrclk_k toggles on the cycle tick_k completes BCLK_PER_FRAME/2 ticks; counter cleared with accumulator (load, leave RUN).
REQ-032 Macro undefined: lrclk port and counters absent; all other behaviour identical.

Structure
REQ-033 Package audio_clock_pkg SHALL hold the FSM state enumeration and default constants for ACC_W, LOCK_CYCLES, BCLK_PER_FRAME.
REQ-034 Sub-module audio_clock_nco SHALL implement one channel (inc_reg, accumulator, clk_out, tick, optional LR counter), instantiated N_CH times via generate.

Verification
REQ-035 Reset then pll_locked=1 steady, LOCK_CYCLES=16 -> locked rises exactly 2+16 cycles after pll_locked rises (±1 for async sample).
REQ-036 ACC_W=24, RUN, load inc0=2^22, inc1=2^23 -> clk_out0 period 4 (2 high/2 low), clk_out1 period 2, one tick per period each.
REQ-037 pll_locked glitch low 1 cycle during SETTLE at count 10 -> FSM returns UNLOCKED, locked rises LOCK_CYCLES after lock restored.
REQ-038 RUN, enable=0 for 7 cycles mid-period -> clk_out frozen, no ticks, phase resumes exactly where held.
REQ-039 rst_n asserted mid-RUN, asynchronously between edges -> all outputs 0 immediately; inc_reg=0 so clk_out stays 0 after relock until new load.
REQ-040 With AUDIO_CLOCK_LRCLK_EN, BCLK_PER_FRAME=64, inc=2^22 -> lrclk period 256 refclk cycles, toggling on every 32nd tick.
